wb_backward_arbiter: RTL and testbench

- Merges write-response (B-channel) words from NUM_IN ID-filtered slave-side sources into a single master-side B stream.
- Uses round-robin arbitration and a one-deep registered output stage.
- Sits downstream of the per-slave ID filter stages in the AXI4 interconnect.
- Each winning word is forwarded unchanged, tagged with its source index, and held stable until the master accepts it.

---
 rtl/wb_backward_arbiter.sv | 79 +++++++
 tb/tb_wb_backward_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/wb_backward_arbiter.sv
// wb_backward_arbiter: round-robin merge of B-channel words
// into one registered master-side stream.
module wb_backward_arbiter #(
    parameter int NUM_IN = 4,
    parameter int IDX_W  = 2,
    parameter int DATA_W = 14
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_IN*DATA_W-1:0] DATAi,
    input  logic [NUM_IN-1:0]        VALIDi,
    output logic [NUM_IN-1:0]        READYi,
    output logic [DATA_W-1:0]        DATAo,
    output logic                     VALIDo,
    input  logic                     READYo,
    output logic [IDX_W-1:0]         GRANTo
);

    logic [IDX_W-1:0]  r_last;
    logic [IDX_W-1:0]  r_grant;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    logic              w_load_en;
    logic              w_found;
    logic [IDX_W-1:0]  w_win;
    logic [IDX_W-1:0]  w_k;
    logic [DATA_W-1:0] w_word;

    assign w_load_en = (~r_valid | READYo) & ~RST;

    // Scan sources starting just after the last winner; first valid wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_k     = '0;
        for (int i = 1; i <= NUM_IN; i++) begin
            w_k = IDX_W'((int'(r_last) + i) % NUM_IN);
            if (!w_found && VALIDi[w_k]) begin
                w_found = 1'b1;
                w_win   = w_k;
            end
        end
    end

    // Mux the winning word and raise ready only on the winner.
    always_comb begin
        w_word = '0;
        READYi = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (w_win == IDX_W'(k)) begin
                w_word    = DATAi[k*DATA_W +: DATA_W];
                READYi[k] = w_load_en & w_found;
            end
        end
    end

    // Output register: load on grant, drain on accept, else hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_grant <= '0;
            r_last  <= IDX_W'(NUM_IN - 1);
        end else if (w_load_en && w_found) begin
            r_valid <= 1'b1;
            r_data  <= w_word;
            r_grant <= w_win;
            r_last  <= w_win;
        end else if (READYo && r_valid) begin
            r_valid <= 1'b0;
        end
    end

    assign DATAo  = r_data;
    assign VALIDo = r_valid;
    assign GRANTo = r_grant;

endmodule

// File: tb/tb_wb_backward_arbiter.sv
// tb_wb_backward_arbiter: directed checks of arbitration,
// backpressure, fairness and reset for wb_backward_arbiter.
module tb_wb_backward_arbiter;

    localparam int NI = 4;
    localparam int IW = 2;
    localparam int DW = 14;

    logic             CLK;
    logic             RST;
    logic [NI*DW-1:0] DATAi;
    logic [NI-1:0]    VALIDi;
    logic [NI-1:0]    READYi;
    logic [DW-1:0]    DATAo;
    logic             VALIDo;
    logic             READYo;
    logic [IW-1:0]    GRANTo;

    int n_checks;
    int n_fail;

    wb_backward_arbiter #(
        .NUM_IN(NI),
        .IDX_W (IW),
        .DATA_W(DW)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .DATAi (DATAi),
        .VALIDi(VALIDi),
        .READYi(READYi),
        .DATAo (DATAo),
        .VALIDo(VALIDo),
        .READYo(READYo),
        .GRANTo(GRANTo)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_word(input int k, input logic [DW-1:0] v);
        DATAi[k*DW +: DW] = v;
    endtask

    // Step to the next falling edge, then let combinational paths settle.
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST      = 1'b1;
        VALIDi   = 4'b1111;
        READYo   = 1'b1;
        DATAi    = '0;

        // Reset: ready must stay low even with every source valid.
        step();
        step();
        chk("rst_readyi", 32'(READYi), 32'h0);
        chk("rst_valido", 32'(VALIDo), 32'h0);
        chk("rst_datao", 32'(DATAo), 32'h0);
        chk("rst_granto", 32'(GRANTo), 32'h0);

        // Idle after reset.
        @(negedge CLK);
        RST    = 1'b0;
        VALIDi = 4'b0000;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("idle_valido", 32'(VALIDo), 32'h0);
            chk("idle_readyi", 32'(READYi), 32'h0);
            chk("idle_granto", 32'(GRANTo), 32'h0);
            step();
        end

        // Single source 2.
        VALIDi = 4'b0100;
        set_word(2, 14'h1A5);
        #1;
        chk("single_ready0", 32'(READYi), 32'h4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("single_ready", 32'(READYi), 32'h4);
            chk("single_valid", 32'(VALIDo), 32'h1);
            chk("single_data", 32'(DATAo), 32'h1A5);
            chk("single_grant", 32'(GRANTo), 32'h2);
        end
        VALIDi = 4'b0000;
        step();
        chk("single_drain", 32'(VALIDo), 32'h0);

        // Reset pointer so source 0 leads the round robin.
        RST = 1'b1;
        step();
        RST = 1'b0;

        // All four valid: grants 0,1,2,3,0,1 one per cycle.
        for (int k = 0; k < NI; k++) set_word(k, DW'(14'h10 + k));
        VALIDi = 4'b1111;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("rr_ready", 32'(READYi), 32'(1 << (i % 4)));
            if (i > 0) begin
                chk("rr_valid", 32'(VALIDo), 32'h1);
                chk("rr_data", 32'(DATAo), 32'(14'h10 + (i - 1) % 4));
                chk("rr_grant", 32'(GRANTo), 32'((i - 1) % 4));
            end
            step();
        end
        chk("rr_last_data", 32'(DATAo), 32'h11);

        // Backpressure holds word 0x11 stable.
        READYo = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", 32'(READYi), 32'h0);
            chk("bp_valid", 32'(VALIDo), 32'h1);
            chk("bp_data", 32'(DATAo), 32'h11);
            chk("bp_grant", 32'(GRANTo), 32'h1);
            step();
        end
        READYo = 1'b1;
        #1;
        chk("bp_release_ready", 32'(READYi), 32'h4);
        step();
        chk("bp_reload_valid", 32'(VALIDo), 32'h1);
        chk("bp_reload_data", 32'(DATAo), 32'h12);
        chk("bp_reload_grant", 32'(GRANTo), 32'h2);

        // Fairness: source 3 wins right after a source-0 grant.
        VALIDi = 4'b0001;
        #1;
        chk("fair_ready0", 32'(READYi), 32'h1);
        step();
        chk("fair_grant0", 32'(GRANTo), 32'h0);
        VALIDi = 4'b1001;
        #1;
        chk("fair_ready3", 32'(READYi), 32'h8);
        step();
        chk("fair_grant3", 32'(GRANTo), 32'h3);
        chk("fair_data3", 32'(DATAo), 32'h13);
        VALIDi = 4'b0001;
        #1;
        chk("fair_ready0b", 32'(READYi), 32'h1);
        step();
        chk("fair_grant0b", 32'(GRANTo), 32'h0);
        chk("fair_data0b", 32'(DATAo), 32'h10);

        // Mid-stream reset drops the held word.
        chk("mrst_pre_valid", 32'(VALIDo), 32'h1);
        RST    = 1'b1;
        VALIDi = 4'b0110;
        #1;
        chk("mrst_ready", 32'(READYi), 32'h0);
        step();
        chk("mrst_valid", 32'(VALIDo), 32'h0);
        chk("mrst_data", 32'(DATAo), 32'h0);
        RST = 1'b0;
        #1;
        chk("mrst_ready_after", 32'(READYi), 32'h2);
        step();
        chk("mrst_grant", 32'(GRANTo), 32'h1);
        chk("mrst_gdata", 32'(DATAo), 32'h11);
        chk("mrst_gvalid", 32'(VALIDo), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
